// File: rtl/uart_tx_ctrl_if.sv
// TX FIFO command/data bundle between uart_tx_ctrl (master) and the TX word FIFO (slave).
interface uart_tx_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic [1:0]       uart_op;

  modport master (input fifo_empty, input fifo_rdata, output uart_op);
  modport slave  (output fifo_empty, output fifo_rdata, input uart_op);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit scheduler: pops words from the TX FIFO and serializes
// BYTES_PER_WORD bytes per word (LSB byte first) as 8N1 frames on tx_o.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned BYTES_PER_WORD = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  uart_tx_ctrl_if.master fifo,
  output logic           tx_o,
  output logic           busy_o,
  output logic           word_done_o
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [1:0]         uart_op_q, uart_op_d;
  logic               busy_q, busy_d;
  logic               word_done_q, word_done_d;
  logic               baud_wrap;
  logic [7:0]         cur_byte_d;

  assign baud_wrap = (baud_q == BAUD_LAST);

  // Next-state, counters and the registered-output values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_wrap ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;

    case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (en_i && !fifo.fifo_empty) state_d = S_POP;
      end
      S_POP: begin
        baud_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        baud_d     = '0;
        shift_d    = fifo.fifo_rdata;
        byte_idx_d = '0;
        state_d    = S_START;
      end
      S_START: begin
        if (baud_wrap) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_wrap) begin
          if (byte_idx_q < BYTE_LAST) begin
            shift_d    = shift_q >> 8;
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so they line up with state_q.
    cur_byte_d  = shift_d[7:0];
    uart_op_d   = (state_d == S_POP) ? OP_POP : OP_NONE;
    busy_d      = (state_d != S_IDLE);
    word_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset parks the line high in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      uart_op_q   <= OP_NONE;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      uart_op_q   <= uart_op_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign fifo.uart_op = uart_op_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign word_done_o  = word_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a 1-byte-per-word and a 4-byte-per-word
// instance, each fed by a small queue-backed FIFO model. CLKS_PER_BIT = 4.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic tx1, busy1, wdone1;
  logic tx4, busy4, wdone4;

  int n_chk = 0;
  int n_pass = 0;
  int pops1 = 0, wd_cnt1 = 0, busy_cnt1 = 0;
  int pops4 = 0, wd_cnt4 = 0;

  logic [31:0] q1[$];
  logic [31:0] q4[$];

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(32)) f1 ();
  uart_tx_ctrl_if #(.WIDTH(32)) f4 ();

  uart_tx_ctrl #(.WIDTH(32), .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(1)) dut (
    .clk(clk), .reset(reset), .en_i(en), .fifo(f1.master),
    .tx_o(tx1), .busy_o(busy1), .word_done_o(wdone1));

  uart_tx_ctrl #(.WIDTH(32), .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(4)) dut4 (
    .clk(clk), .reset(reset), .en_i(en), .fifo(f4.master),
    .tx_o(tx4), .busy_o(busy4), .word_done_o(wdone4));

  // FIFO models: registered data_out, all-ones on an empty read.
  always @(posedge clk) begin
    if (f1.uart_op == 2'b01) f1.fifo_rdata <= (q1.size() != 0) ? q1.pop_front() : 32'hFFFF_FFFF;
    f1.fifo_empty <= (q1.size() == 0);
    if (f4.uart_op == 2'b01) f4.fifo_rdata <= (q4.size() != 0) ? q4.pop_front() : 32'hFFFF_FFFF;
    f4.fifo_empty <= (q4.size() == 0);
  end

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (f1.uart_op == 2'b01) pops1++;
    if (wdone1) wd_cnt1++;
    if (busy1) busy_cnt1++;
    if (f4.uart_op == 2'b01) pops4++;
    if (wdone4) wd_cnt4++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 4) ? tx4 : tx1;
  endfunction

  // Waits (bounded) for the first low cycle of a start bit.
  task automatic wait_start(input int sel);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (tx_of(sel) == 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("start_seen", 32'(seen), 32'd1);
  endtask

  // Samples each bit mid-period; returns on the first cycle after the frame.
  task automatic recv_frame(input int sel, output logic [10:0] f);
    f = '1;
    for (int c = 0; c < int'(NBITS * CPB); c++) begin
      if (c % CPB == 2) f[c / CPB] = tx_of(sel);
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int sel, input logic [7:0] exp);
    logic [10:0] f;
    recv_frame(sel, f);
    check_eq({tag, "_start"}, 32'(f[0]), 32'd0);
    check_eq({tag, "_data"}, 32'(f[8:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
    check_eq({tag, "_par"}, 32'(f[9]), 32'(^exp));
`endif
    check_eq({tag, "_stop"}, 32'(f[NBITS-1]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, w, b, g;
    logic [10:0] fr;
    logic [7:0] bytes4 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

    // Reset idle: line high, no pop, not busy, even with en=1 and empty FIFO.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_tx", 32'(tx1), 32'd1);
      check_eq("rst_op", 32'(f1.uart_op), 32'd0);
      check_eq("rst_busy", 32'(busy1), 32'd0);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("no_pop_empty", 32'(pops1 + pops4), 32'd0);
    check_eq("idle_tx", 32'(tx1), 32'd1);

    // Single byte 0x55; busy spans POP + LOAD + one full frame.
    p = pops1; w = wd_cnt1; b = busy_cnt1;
    q1.push_back(32'h0000_0055);
    wait_start(1);
    check_frame("b55", 1, 8'h55);
    repeat (5) @(negedge clk);
    check_eq("b55_pops", 32'(pops1 - p), 32'd1);
    check_eq("b55_wdone", 32'(wd_cnt1 - w), 32'd1);
    check_eq("b55_busy", 32'(busy_cnt1 - b), 32'(2 + NBITS * CPB));

    // Four bytes per word, LSB byte first, no gap between bytes.
    p = pops4; w = wd_cnt4;
    q4.push_back(32'hA1B2_C3D4);
    wait_start(4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check_eq("mb_no_gap", 32'(tx4), 32'd0);
      check_frame("mb", 4, bytes4[i]);
    end
    repeat (5) @(negedge clk);
    check_eq("mb_pops", 32'(pops4 - p), 32'd1);
    check_eq("mb_wdone", 32'(wd_cnt4 - w), 32'd1);

    // Back-to-back words: exactly IDLE, POP, LOAD high between frames.
    p = pops1; w = wd_cnt1;
    q1.push_back(32'h0000_0012);
    q1.push_back(32'h0000_0034);
    wait_start(1);
    check_frame("bb0", 1, 8'h12);
    g = 0;
    while (tx1 == 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    check_eq("bb_gap", 32'(g), 32'd3);
    check_frame("bb1", 1, 8'h34);
    repeat (5) @(negedge clk);
    check_eq("bb_pops", 32'(pops1 - p), 32'd2);
    check_eq("bb_wdone", 32'(wd_cnt1 - w), 32'd2);

    // en dropped mid-DATA: frame completes, queued word stays until en returns.
    q1.push_back(32'h0000_003C);
    q1.push_back(32'h0000_0099);
    wait_start(1);
    fork
      check_frame("en3C", 1, 8'h3C);
      begin
        repeat (12) @(negedge clk);
        en = 1'b0;
      end
    join
    p = pops1;
    repeat (40) @(negedge clk);
    check_eq("en_no_pop", 32'(pops1 - p), 32'd0);
    check_eq("en_idle", 32'(busy1), 32'd0);
    check_eq("en_queued", 32'(q1.size()), 32'd1);
    en = 1'b1;
    wait_start(1);
    check_frame("en99", 1, 8'h99);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0): line high on the next cycle.
    repeat (3) @(negedge clk);
    q1.push_back(32'h0000_00A5);
    wait_start(1);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    check_eq("rb_bit3_low", 32'(tx1), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rb_tx", 32'(tx1), 32'd1);
    check_eq("rb_busy", 32'(busy1), 32'd0);
    check_eq("rb_op", 32'(f1.uart_op), 32'd0);
    reset = 1'b0;
    q1.push_back(32'h0000_00C3);
    wait_start(1);
    check_frame("rbC3", 1, 8'hC3);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two.
    q1.push_back(32'h0000_0007);
    wait_start(1);
    recv_frame(1, fr);
    check_eq("par07_data", 32'(fr[8:1]), 32'h07);
    check_eq("par07_bit", 32'(fr[9]), 32'd1);
    check_eq("par07_stop", 32'(fr[10]), 32'd1);
    q1.push_back(32'h0000_0003);
    wait_start(1);
    recv_frame(1, fr);
    check_eq("par03_data", 32'(fr[8:1]), 32'h03);
    check_eq("par03_bit", 32'(fr[9]), 32'd0);
    check_eq("par03_stop", 32'(fr[10]), 32'd1);
`else
    fr = '0;
`endif

    repeat (5) @(negedge clk);
    check_eq("end_idle_tx", 32'(tx1), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
